// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the calculator arithmetic units.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam int CALC_WIDTH = 32;

    localparam logic [CALC_WIDTH-1:0] DIV0_QUOTIENT = {CALC_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } div_state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division step: shift in a dividend bit, trial
//               subtract the divisor magnitude, keep or restore.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // rem_in < divisor, so the true difference fits a signed WIDTH+1 value
    assign w_shifted = {rem_in, bit_in};
    assign w_diff    = w_shifted - {1'b0, divisor};
    assign q_bit     = ~w_diff[WIDTH];
    assign rem_out   = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential radix-2 restoring divider, signed/unsigned, with
//               divide-by-zero and signed-overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_DIV0_Q = WIDTH'(DIV0_QUOTIENT);

    div_state_t       r_state;
    div_state_t       w_next;

    logic             r_signed;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;

    // In PREP, r_q and r_dvs still hold the raw captured operands
    assign w_a_mag = (r_signed && r_q[WIDTH-1])   ? -r_q   : r_q;
    assign w_b_mag = (r_signed && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;
    assign busy    = (r_state != IDLE);

    div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .rem_in  (r_rem),
        .bit_in  (r_q[WIDTH-1]),
        .divisor (r_dvs),
        .rem_out (w_rem_next),
        .q_bit   (w_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = PREP;
            PREP:    w_next = (r_dvs == '0) ? FIX : DIV;
            DIV:     if (r_cnt == C_LAST) w_next = FIX;
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_signed    <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_dividend  <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_signed   <= is_signed;
                        r_dividend <= dividend;
                        r_q        <= dividend;
                        r_dvs      <= divisor;
                    end
                end
                PREP: begin
                    r_sign_q <= r_signed & (r_q[WIDTH-1] ^ r_dvs[WIDTH-1]);
                    r_sign_r <= r_signed & r_q[WIDTH-1];
                    r_dbz    <= (r_dvs == '0);
                    r_ovf    <= r_signed && (r_q == C_MINNEG) && (r_dvs == '1);
                    r_q      <= w_a_mag;
                    r_dvs    <= w_b_mag;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= r_dbz;
                    if (r_dbz) begin
                        quotient  <= C_DIV0_Q;
                        remainder <= r_dividend;
                        overflow  <= 1'b0;
                    end else begin
                        quotient  <= r_sign_q ? -r_q   : r_q;
                        remainder <= r_sign_r ? -r_rem : r_rem;
                        overflow  <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_divider
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_tests;
    int n_failed;

    seq_divider #(
        .WIDTH       (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one operation; returns cycles from the start edge to done (-1 if none).
    // poke_at: cycle at which a stray start with other operands is pulsed.
    // rst_at : cycle at which reset is asserted to abort the operation.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int rst_at,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == poke_at) begin
                start     = 1'b1;
                is_signed = 1'b0;
                dividend  = 32'd999;
                divisor   = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check("abort_quot", quotient, 32'd0);
                check("abort_rem",  remainder, 32'd0);
                check("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
                reset = 1'b0;
                return;
            end
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic do_case(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic edbz, input logic eovf,
                           input int elat);
        int lat;
        int bc;
        run_op(s, a, b, 0, 0, lat, bc);
        check({tag, "_lat"},   lat, elat);
        check({tag, "_quot"},  quotient, eq);
        check({tag, "_rem"},   remainder, er);
        check({tag, "_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, edbz, eovf});
    endtask

    initial begin
        int lat;
        int bc;
        int done_seen;
        n_tests   = 0;
        n_failed  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_quot",  quotient, 32'd0);
        check("rst_rem",   remainder, 32'd0);
        check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);

        // Unsigned 100/7 with latency and busy profile
        run_op(1'b0, 32'd100, 32'd7, 0, 0, lat, bc);
        check("u100_7_lat",  lat, 32'd34);
        check("u100_7_busy", bc, 32'd33);
        check("u100_7_busy_at_done", {31'd0, busy}, 32'd0);
        check("u100_7_quot", quotient, 32'd14);
        check("u100_7_rem",  remainder, 32'd2);
        check("u100_7_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        @(posedge clk);
        #1;
        check("done_pulse_len", {31'd0, done}, 32'd0);
        check("held_quot", quotient, 32'd14);

        do_case("sm7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 34);
        do_case("s7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0, 34);
        do_case("sm100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 34);
        do_case("uffff_1",  1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0, 34);
        do_case("uffff_2",  1'b0, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 32'd1,        1'b0, 1'b0, 34);
        do_case("sovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 1'b1, 34);
        do_case("u5_0",     1'b0, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1'b0, 2);
        do_case("s5_0",     1'b1, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1, 1'b0, 2);

        // Stray start mid-operation must be ignored
        run_op(1'b0, 32'd100, 32'd7, 10, 0, lat, bc);
        check("poke_lat",  lat, 32'd34);
        check("poke_quot", quotient, 32'd14);
        check("poke_rem",  remainder, 32'd2);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("poke_no_second_op", done_seen, 32'd0);

        // Reset abort during DIV step 16, then no late done pulse
        run_op(1'b0, 32'd1000, 32'd3, 0, 17, lat, bc);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        do_case("after_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule : tb_seq_divider
`default_nettype wire
